// File: rtl/ipml_sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read side,
// run-time or fixed almost thresholds and sticky overflow/underflow flags.
module ipml_sync_fifo_fwft #(
    parameter int c_DEPTH_WIDTH      = 9,
    parameter int c_DATA_WIDTH       = 32,
    parameter int c_FWFT             = 0,
    parameter int c_PROG_THRESH_EN   = 0,
    parameter int c_ALMOST_FULL_NUM  = 508,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [c_DATA_WIDTH-1:0] wr_data,
    input  logic                    wr_en,
    output logic                    wr_full,
    output logic                    almost_full,
    output logic                    overflow,
    output logic [c_DATA_WIDTH-1:0] rd_data,
    input  logic                    rd_en,
    output logic                    rd_empty,
    output logic                    almost_empty,
    output logic                    underflow,
    output logic [c_DEPTH_WIDTH:0]  water_level,
    input  logic [c_DEPTH_WIDTH:0]  af_thresh,
    input  logic [c_DEPTH_WIDTH:0]  ae_thresh,
    input  logic                    clr_err
);
    localparam int AW    = c_DEPTH_WIDTH;
    localparam int DW    = c_DATA_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] ONE    = (AW+1)'(1);
    localparam logic [AW:0] AF_DEF = (AW+1)'(c_ALMOST_FULL_NUM);
    localparam logic [AW:0] AE_DEF = (AW+1)'(c_ALMOST_EMPTY_NUM);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg, level_reg, level_next;
    logic [AW:0]   af_th, ae_th;
    logic          mem_full, wr_accept, rd_accept, rd_empty_int;
    logic          almost_full_reg, almost_empty_reg, overflow_reg, underflow_reg;

    assign mem_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign wr_accept = wr_en & ~mem_full;
    assign af_th     = (c_PROG_THRESH_EN != 0) ? af_thresh : AF_DEF;
    assign ae_th     = (c_PROG_THRESH_EN != 0) ? ae_thresh : AE_DEF;

    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wr_ptr_reg <= '0;
        else if (wr_accept)
            wr_ptr_reg <= wr_ptr_reg + ONE;
    end

    always_comb begin
        level_next = level_reg;
        if (wr_accept && !rd_accept)
            level_next = level_reg + ONE;
        else if (!wr_accept && rd_accept)
            level_next = level_reg - ONE;
    end

    // Almost flags follow the next level so they move on the same edge as water_level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_reg        <= '0;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            level_reg        <= level_next;
            almost_full_reg  <= (level_next >= af_th);
            almost_empty_reg <= (level_next <= ae_th);
            if (wr_en && mem_full)
                overflow_reg <= 1'b1;
            else if (clr_err)
                overflow_reg <= 1'b0;
            if (rd_en && rd_empty_int)
                underflow_reg <= 1'b1;
            else if (clr_err)
                underflow_reg <= 1'b0;
        end
    end

    generate
        if (c_FWFT != 0) begin : g_fwft
            // rd_ptr frees a memory slot only once its word has reached the output stage,
            // so an in-flight prefetch still counts against wr_full.
            logic [AW:0]   iss_ptr_reg;
            logic          pf_valid_reg, stage_valid_reg, issue, pf_move;
            logic [DW-1:0] mem_q_reg, stage_data_reg;

            assign rd_accept = rd_en & stage_valid_reg;
            assign pf_move   = pf_valid_reg & (~stage_valid_reg | rd_accept);
            assign issue     = (iss_ptr_reg != wr_ptr_reg) & (~pf_valid_reg | pf_move);

            always_ff @(posedge clk) begin
                if (issue)
                    mem_q_reg <= mem[iss_ptr_reg[AW-1:0]];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    iss_ptr_reg     <= '0;
                    rd_ptr_reg      <= '0;
                    pf_valid_reg    <= 1'b0;
                    stage_valid_reg <= 1'b0;
                    stage_data_reg  <= '0;
                end else begin
                    if (issue)
                        iss_ptr_reg <= iss_ptr_reg + ONE;
                    if (pf_move) begin
                        rd_ptr_reg     <= rd_ptr_reg + ONE;
                        stage_data_reg <= mem_q_reg;
                    end
                    pf_valid_reg    <= issue | (pf_valid_reg & ~pf_move);
                    stage_valid_reg <= pf_move | (stage_valid_reg & ~rd_accept);
                end
            end

            assign rd_empty_int = ~stage_valid_reg;
            assign rd_data      = stage_data_reg;
        end else begin : g_std
            logic [DW-1:0] rd_data_reg;

            assign rd_empty_int = (wr_ptr_reg == rd_ptr_reg);
            assign rd_accept    = rd_en & ~rd_empty_int;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_ptr_reg  <= '0;
                    rd_data_reg <= '0;
                end else if (rd_accept) begin
                    rd_ptr_reg  <= rd_ptr_reg + ONE;
                    rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
                end
            end

            assign rd_data = rd_data_reg;
        end
    endgenerate

    assign wr_full      = mem_full;
    assign rd_empty     = rd_empty_int;
    assign water_level  = level_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;
endmodule

// File: tb/tb_ipml_sync_fifo_fwft.sv
// Bench for ipml_sync_fifo_fwft: a standard-mode and a FWFT-mode instance, both 16 deep,
// checked against queue-based reference models plus directed sequences.
module tb_ipml_sync_fifo_fwft;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       s_wr_en, s_rd_en, s_clr, s_full, s_afull, s_ovf, s_empty, s_aempty, s_unf;
    logic [7:0] s_wr_data, s_rd_data;
    logic [4:0] s_level, s_af, s_ae;
    logic       f_wr_en, f_rd_en, f_clr, f_full, f_afull, f_ovf, f_empty, f_aempty, f_unf;
    logic [7:0] f_wr_data, f_rd_data;
    logic [4:0] f_level, f_af, f_ae;

    ipml_sync_fifo_fwft #(.c_DEPTH_WIDTH(4), .c_DATA_WIDTH(8), .c_FWFT(0), .c_PROG_THRESH_EN(0),
                          .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(2)) u_std (
        .clk(clk), .rst(rst), .wr_data(s_wr_data), .wr_en(s_wr_en), .wr_full(s_full),
        .almost_full(s_afull), .overflow(s_ovf), .rd_data(s_rd_data), .rd_en(s_rd_en),
        .rd_empty(s_empty), .almost_empty(s_aempty), .underflow(s_unf), .water_level(s_level),
        .af_thresh(s_af), .ae_thresh(s_ae), .clr_err(s_clr));

    ipml_sync_fifo_fwft #(.c_DEPTH_WIDTH(4), .c_DATA_WIDTH(8), .c_FWFT(1), .c_PROG_THRESH_EN(1),
                          .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(2)) u_fwft (
        .clk(clk), .rst(rst), .wr_data(f_wr_data), .wr_en(f_wr_en), .wr_full(f_full),
        .almost_full(f_afull), .overflow(f_ovf), .rd_data(f_rd_data), .rd_en(f_rd_en),
        .rd_empty(f_empty), .almost_empty(f_aempty), .underflow(f_unf), .water_level(f_level),
        .af_thresh(f_af), .ae_thresh(f_ae), .clr_err(f_clr));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference state: plain queues; FWFT head visibility from write time and last consume time.
    logic [7:0] sq[$];
    logic [7:0] fq[$];
    int         fw[$];
    bit         sm_ovf, sm_unf, fm_vis, fm_ovf, fm_unf;
    logic [7:0] sm_rd;
    int         fm_lastpop;

    typedef struct {
        bit wr; bit rd; bit clr; logic [7:0] wd;
        bit e_full; bit e_empty; bit e_af; bit e_ae; bit e_ovf; bit e_unf;
        int e_level; logic [7:0] e_rd;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack(input logic full, input logic empty, input logic af,
                                         input logic ae, input logic ovf, input logic unf,
                                         input logic [4:0] lvl);
        return {21'b0, full, empty, af, ae, ovf, unf, lvl};
    endfunction

    task automatic model_reset();
        sq.delete(); fq.delete(); fw.delete();
        sm_ovf = 0; sm_unf = 0; sm_rd = 8'h00;
        fm_vis = 0; fm_ovf = 0; fm_unf = 0; fm_lastpop = -100;
    endtask

    task automatic tick();
        bit full_b, emp_b, was_vis;
        int occ;
        logic [4:0] af_s, ae_s;
        @(posedge clk);
        cyc++;
        full_b = (sq.size() == DEPTH);
        emp_b  = (sq.size() == 0);
        if (s_rd_en && !emp_b) sm_rd = sq.pop_front();
        if (s_wr_en && !full_b) sq.push_back(s_wr_data);
        if (s_wr_en && full_b) sm_ovf = 1; else if (s_clr) sm_ovf = 0;
        if (s_rd_en && emp_b) sm_unf = 1; else if (s_clr) sm_unf = 0;

        af_s = f_af; ae_s = f_ae;
        was_vis = fm_vis;
        occ = fq.size() - (was_vis ? 1 : 0);
        full_b = (occ == DEPTH);
        if (f_rd_en && was_vis) begin
            void'(fq.pop_front()); void'(fw.pop_front()); fm_lastpop = cyc;
        end
        if (f_wr_en && !full_b) begin fq.push_back(f_wr_data); fw.push_back(cyc); end
        if (f_wr_en && full_b) fm_ovf = 1; else if (f_clr) fm_ovf = 0;
        if (f_rd_en && !was_vis) fm_unf = 1; else if (f_clr) fm_unf = 0;
        fm_vis = 0;
        if (fq.size() > 0)
            fm_vis = (cyc >= fw[0] + 2) && (cyc >= fm_lastpop);
        #1;
        chk("std_flags", pack(s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf, s_level),
            pack(sq.size() == DEPTH, sq.size() == 0, sq.size() >= 14, sq.size() <= 2,
                 sm_ovf, sm_unf, 5'(sq.size())));
        chk("std_rd_data", {24'b0, s_rd_data}, {24'b0, sm_rd});
        chk("fwft_flags", pack(f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf, f_level),
            pack((fq.size() - (fm_vis ? 1 : 0)) == DEPTH, !fm_vis, fq.size() >= int'(af_s),
                 fq.size() <= int'(ae_s), fm_ovf, fm_unf, 5'(fq.size())));
        if (fm_vis) chk("fwft_rd_data", {24'b0, f_rd_data}, {24'b0, fq[0]});
    endtask

    task automatic idle_inputs();
        s_wr_en = 0; s_rd_en = 0; s_clr = 0;
        f_wr_en = 0; f_rd_en = 0; f_clr = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_std"}, pack(s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf, s_level),
            pack(0, 1, 0, 1, 0, 0, 5'd0));
        chk({tag, "_std_rd"}, {24'b0, s_rd_data}, 32'h0);
        chk({tag, "_fwft"}, pack(f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf, f_level),
            pack(0, 1, 0, 1, 0, 0, 5'd0));
        chk({tag, "_fwft_rd"}, {24'b0, f_rd_data}, 32'h0);
    endtask

    initial begin
        vec_t v;
        int gaps;
        logic [7:0] got[$];
        int bad;

        idle_inputs();
        s_wr_data = 0; f_wr_data = 0;
        s_af = 5'd1; s_ae = 5'd15;      // must be ignored by the fixed-threshold instance
        f_af = 5'd12; f_ae = 5'd3;
        #1 rst = 1'b1;
        #2 check_reset_state("reset");
        #24 rst = 1'b0;
        model_reset();

        // Standard mode: fill, overflow, drain, underflow, clear.
        for (int i = 0; i < 16; i++) begin
            v = '{wr:1, rd:0, clr:0, wd:8'(i), e_full:(i == 15), e_empty:0, e_af:(i + 1 >= 14),
                  e_ae:(i + 1 <= 2), e_ovf:0, e_unf:0, e_level:i + 1, e_rd:8'h00};
            tbl.push_back(v);
        end
        v = '{wr:1, rd:0, clr:0, wd:8'hEE, e_full:1, e_empty:0, e_af:1, e_ae:0,
              e_ovf:1, e_unf:0, e_level:16, e_rd:8'h00};
        tbl.push_back(v);
        for (int j = 0; j < 16; j++) begin
            v = '{wr:0, rd:1, clr:0, wd:8'h00, e_full:0, e_empty:(j == 15), e_af:(15 - j >= 14),
                  e_ae:(15 - j <= 2), e_ovf:1, e_unf:0, e_level:15 - j, e_rd:8'(j)};
            tbl.push_back(v);
        end
        v = '{wr:0, rd:1, clr:0, wd:8'h00, e_full:0, e_empty:1, e_af:0, e_ae:1,
              e_ovf:1, e_unf:1, e_level:0, e_rd:8'd15};
        tbl.push_back(v);
        v = '{wr:0, rd:0, clr:1, wd:8'h00, e_full:0, e_empty:1, e_af:0, e_ae:1,
              e_ovf:0, e_unf:0, e_level:0, e_rd:8'd15};
        tbl.push_back(v);

        foreach (tbl[i]) begin
            s_wr_en = tbl[i].wr; s_rd_en = tbl[i].rd; s_clr = tbl[i].clr; s_wr_data = tbl[i].wd;
            tick();
            chk($sformatf("tbl%0d_flags", i), pack(s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf, s_level),
                pack(tbl[i].e_full, tbl[i].e_empty, tbl[i].e_af, tbl[i].e_ae, tbl[i].e_ovf,
                     tbl[i].e_unf, 5'(tbl[i].e_level)));
            chk($sformatf("tbl%0d_rd", i), {24'b0, s_rd_data}, {24'b0, tbl[i].e_rd});
        end
        idle_inputs();

        // FWFT: single write into an empty FIFO appears two edges later.
        f_wr_en = 1; f_wr_data = 8'hA5;
        tick();
        f_wr_en = 0;
        chk("fwft_lat_n0", {31'b0, f_empty}, 32'd1);
        tick();
        chk("fwft_lat_n1", {31'b0, f_empty}, 32'd1);
        tick();
        chk("fwft_lat_n2", {31'b0, f_empty}, 32'd0);
        chk("fwft_lat_data", {24'b0, f_rd_data}, 32'hA5);
        f_rd_en = 1;
        tick();
        f_rd_en = 0;
        chk("fwft_lat_drain", {26'b0, f_empty, f_level}, {26'b0, 1'b1, 5'd0});

        // FWFT streaming at one word per cycle.
        gaps = 0;
        for (int t = 0; t <= 102; t++) begin
            f_wr_en = (t < 100); f_wr_data = 8'(t);
            f_rd_en = (t >= 3);
            if (f_rd_en) begin
                if (f_empty) gaps++;
                else got.push_back(f_rd_data);
            end
            tick();
        end
        idle_inputs();
        bad = 0;
        foreach (got[i]) if (got[i] !== 8'(i)) bad++;
        chk("stream_gaps", gaps, 0);
        chk("stream_count", got.size(), 100);
        chk("stream_order", bad, 0);
        chk("stream_errs", {30'b0, f_ovf, f_unf}, 32'd0);

        // Programmable thresholds.
        for (int i = 0; i < 12; i++) begin
            f_wr_en = 1; f_wr_data = 8'(8'h80 + i);
            tick();
            chk($sformatf("af_at_%0d", i + 1), {31'b0, f_afull}, (i + 1 == 12) ? 32'd1 : 32'd0);
            chk($sformatf("ae_at_%0d", i + 1), {31'b0, f_aempty}, (i + 1 <= 3) ? 32'd1 : 32'd0);
        end
        f_wr_en = 0; f_rd_en = 1;
        tick(); tick();
        f_rd_en = 0;
        chk("af_level10", {26'b0, f_afull, f_level}, {26'b0, 1'b0, 5'd10});
        f_af = 5'd8;
        tick();
        chk("af_thresh8", {31'b0, f_afull}, 32'd1);
        f_rd_en = 1;
        for (int i = 0; i < 10; i++) tick();
        f_rd_en = 0; f_af = 5'd12;

        // Standard-mode boundaries.
        s_rd_en = 1; tick(); s_rd_en = 0;
        chk("unf_on_empty", {31'b0, s_unf}, 32'd1);
        s_wr_en = 1; s_wr_data = 8'h11; tick();
        s_rd_en = 1; s_wr_data = 8'h22; tick();
        chk("rw_level1", {27'b0, s_level}, 32'd1);
        chk("rw_data", {24'b0, s_rd_data}, 32'h11);
        s_wr_en = 0; tick();
        chk("after_rw_data", {24'b0, s_rd_data}, 32'h22);
        s_rd_en = 0; s_clr = 1; tick(); s_clr = 0;
        for (int i = 0; i < 16; i++) begin
            s_wr_en = 1; s_wr_data = 8'(8'h30 + i); tick();
        end
        s_wr_data = 8'h99; tick();
        chk("ovf_set", {31'b0, s_ovf}, 32'd1);
        s_clr = 1; tick();
        chk("ovf_set_beats_clr", {31'b0, s_ovf}, 32'd1);
        s_wr_en = 0; tick(); s_clr = 0;
        chk("ovf_cleared", {31'b0, s_ovf}, 32'd0);
        s_rd_en = 1;
        for (int i = 0; i < 16; i++) tick();
        s_rd_en = 0;
        chk("last_word", {24'b0, s_rd_data}, 32'h3F);

        // Randomised traffic against the models.
        for (int ph = 0; ph < 8; ph++) begin
            int pw;
            pw = (ph % 2 == 0) ? 80 : 25;
            for (int c = 0; c < 100; c++) begin
                if (c % 25 == 0) begin
                    f_af = (ph == 3) ? 5'd0 : 5'($urandom_range(0, 17));
                    f_ae = 5'($urandom_range(0, 17));
                end
                s_wr_en = ($urandom_range(0, 99) < pw); s_wr_data = 8'($urandom);
                s_rd_en = ($urandom_range(0, 99) < 105 - pw); s_clr = ($urandom_range(0, 99) < 3);
                f_wr_en = ($urandom_range(0, 99) < pw); f_wr_data = 8'($urandom);
                f_rd_en = ($urandom_range(0, 99) < 105 - pw); f_clr = ($urandom_range(0, 99) < 3);
                tick();
            end
        end
        idle_inputs();

        // Async reset in the middle of a burst at level 9.
        s_rd_en = 1; f_rd_en = 1;
        for (int i = 0; i < 22; i++) tick();
        idle_inputs();
        for (int i = 0; i < 9; i++) begin
            s_wr_en = 1; f_wr_en = 1; s_wr_data = 8'(8'h50 + i); f_wr_data = 8'(8'h60 + i);
            tick();
        end
        chk("pre_reset_levels", {22'b0, s_level, f_level}, {22'b0, 5'd9, 5'd9});
        #3 rst = 1'b1;
        #1 check_reset_state("async_reset");
        idle_inputs();
        #2 rst = 1'b0;
        model_reset();
        s_wr_en = 1; f_wr_en = 1; s_wr_data = 8'h3C; f_wr_data = 8'h3C;
        tick();
        idle_inputs();
        s_rd_en = 1; tick(); s_rd_en = 0;
        chk("post_reset_std", {23'b0, s_empty, s_rd_data}, {23'b0, 1'b1, 8'h3C});
        tick();
        chk("post_reset_fwft", {23'b0, f_empty, f_rd_data}, {23'b0, 1'b0, 8'h3C});
        f_rd_en = 1; tick(); f_rd_en = 0;
        chk("post_reset_fwft_level", {27'b0, f_level}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
